// File: rtl/lane_symbol_gearbox.sv
// Byte gearbox: accepts 1/2/4-byte scrambled words into a small byte FIFO and
// emits one symbol (8 bits + K flag) per output handshake toward the 8b/10b encoder.
module lane_symbol_gearbox #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                data_i,
  input  logic [3:0]                 datak_i,
  input  logic [1:0]                 data_len_i,
  output logic                       sym_valid_o,
  input  logic                       sym_ready_i,
  output logic [7:0]                 sym_o,
  output logic                       symk_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       len_err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem_data [DEPTH];
  logic          r_mem_k    [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_len_err;

  logic          w_hs;
  logic          w_len_ok;
  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_n;
  logic [2:0]    w_n_push;
  logic [AW:0]   w_count_next;

  always_comb begin
    w_n = 3'd0;
    case (data_len_i)
      2'b00:   w_n = 3'd1;
      2'b01:   w_n = 3'd2;
      2'b10:   w_n = 3'd4;
      default: w_n = 3'd0;
    endcase
  end

  // Ready only when a worst-case 4-byte word fits, so overflow cannot occur.
  assign in_ready_o   = (r_count <= (AW+1)'(DEPTH - 4));
  assign w_hs         = in_valid_i & in_ready_o;
  assign w_len_ok     = (data_len_i != 2'b11);
  assign w_push       = w_hs & w_len_ok;
  assign w_n_push     = w_push ? w_n : 3'd0;
  assign sym_valid_o  = (r_count != '0);
  assign w_pop        = sym_valid_o & sym_ready_i;
  assign w_count_next = r_count + (AW+1)'(w_n_push) - (AW+1)'(w_pop);

  assign sym_o     = r_mem_data[r_rd_ptr];
  assign symk_o    = r_mem_k[r_rd_ptr];
  assign level_o   = r_count;
  assign len_err_o = r_len_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_len_err <= 1'b0;
    end else begin
      // The error pulse reports the handshake even when a flush discards the cycle.
      r_len_err <= w_hs & ~w_len_ok;
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
        r_rd_ptr <= r_rd_ptr + AW'(w_pop);
        r_count  <= w_count_next;
      end
    end
  end

  // Storage carries no reset; only occupied entries are ever presented.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(w_n)) begin
          r_mem_data[r_wr_ptr + AW'(k)] <= data_i[8*k +: 8];
          r_mem_k[r_wr_ptr + AW'(k)]    <= datak_i[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_symbol_gearbox.sv
// Bench for lane_symbol_gearbox: the driver queues expected symbols at each
// accepted word, a negedge monitor pops and compares every output handshake.
module tb_lane_symbol_gearbox;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   data_i = '0;
  logic [3:0]    datak_i = '0;
  logic [1:0]    data_len_i = '0;
  logic          sym_valid_o;
  logic          sym_ready_i = 1'b0;
  logic [7:0]    sym_o;
  logic          symk_o;
  logic [AW:0]   level_o;
  logic          len_err_o;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  lane_symbol_gearbox #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .datak_i     (datak_i),
    .data_len_i  (data_len_i),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i),
    .sym_o       (sym_o),
    .symk_o      (symk_o),
    .level_o     (level_o),
    .len_err_o   (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && sym_valid_o && sym_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sym_unexpected actual %h k %b required none", sym_o, symk_o);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({symk_o, sym_o} !== e) begin
          errors++;
          $display("FAIL sym_stream actual k%b %h required k%b %h", symk_o, sym_o, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one word and holds it until accepted; expected bytes queued at handshake.
  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic [1:0] len);
    int n;
    bit done;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : (len == 2'b10) ? 4 : 0;
    in_valid_i = 1'b1;
    data_i     = d;
    datak_i    = k;
    data_len_i = len;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (in_ready_o) begin
        for (int b = 0; b < n; b++) exp_q.push_back({k[b], d[8*b +: 8]});
        done = 1;
      end
      tick();
    end
    in_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual in_ready %b required 1", in_ready_o);
    end
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (level_o == 0 && exp_q.size() == 0) done = 1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain actual level %0d queued %0d required 0", name, level_o, exp_q.size());
    end
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    #22 rst_i = 1'b0;
    tick();
    check("rst_valid", 32'(sym_valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_ready", 32'(in_ready_o), 32'd1);
    check("rst_lenerr", 32'(len_err_o), 32'd0);

    // Single 4-byte word, downstream always ready.
    sym_ready_i = 1'b1;
    send_word(32'hA1B2C3D4, 4'b0001, 2'b10);
    check("w4_level0", 32'(level_o), 32'd4);
    for (int i = 3; i >= 0; i--) begin
      tick();
      check("w4_level", 32'(level_o), 32'(i));
    end

    // Backpressure and full boundary with 1-byte words.
    sym_ready_i = 1'b0;
    send_word(32'h11, 4'b0, 2'b00);
    send_word(32'h22, 4'b0, 2'b00);
    send_word(32'h33, 4'b0, 2'b00);
    send_word(32'h44, 4'b0, 2'b00);
    check("bp_ready_at4", 32'(in_ready_o), 32'd1);
    send_word(32'h55, 4'b0, 2'b00);
    check("bp_ready_at5", 32'(in_ready_o), 32'd0);
    check("bp_level", 32'(level_o), 32'd5);
    check("bp_sym", 32'(sym_o), 32'h11);
    tick();
    tick();
    check("bp_sym_hold", 32'(sym_o), 32'h11);
    check("bp_valid", 32'(sym_valid_o), 32'd1);
    sym_ready_i = 1'b1;
    wait_empty("bp");

    // Mixed lengths: 7 symbols, one per cycle with no gaps.
    send_word(32'h00000007, 4'b0, 2'b00);
    send_word(32'h00000908, 4'b0, 2'b01);
    send_word(32'h0D0C0B0A, 4'b0, 2'b10);
    check("mix_level", 32'(level_o), 32'd5);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("mix_nogap", 32'(level_o), 32'(i));
    end

    // Pointer wrap: advance by 6 more (total 22 = 6 mod 8), then straddle the end.
    send_word(32'h0000BBAA, 4'b0010, 2'b01);
    send_word(32'h0000DDCC, 4'b0000, 2'b01);
    send_word(32'h0000FFEE, 4'b0001, 2'b01);
    wait_empty("pre_wrap");
    send_word(32'h44332211, 4'b1000, 2'b10);
    wait_empty("wrap");

    // Illegal length, then flush with simultaneous push.
    sym_ready_i = 1'b0;
    send_word(32'h01, 4'b0, 2'b00);
    send_word(32'h02, 4'b0, 2'b00);
    send_word(32'h03, 4'b0, 2'b00);
    send_word(32'hDEADBEEF, 4'b1111, 2'b11);
    check("illegal_pulse", 32'(len_err_o), 32'd1);
    check("illegal_level", 32'(level_o), 32'd3);
    tick();
    check("illegal_pulse_end", 32'(len_err_o), 32'd0);
    check("illegal_level_hold", 32'(level_o), 32'd3);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    data_i     = 32'h99;
    data_len_i = 2'b00;
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    exp_q.delete();
    check("flush_level", 32'(level_o), 32'd0);
    check("flush_valid", 32'(sym_valid_o), 32'd0);
    sym_ready_i = 1'b1;
    send_word(32'h5A, 4'b0001, 2'b00);
    wait_empty("post_flush");

    // Asynchronous reset with count 6.
    sym_ready_i = 1'b0;
    send_word(32'h87654321, 4'b0, 2'b10);
    send_word(32'h0000CAFE, 4'b0, 2'b01);
    check("prerst_level", 32'(level_o), 32'd6);
    check("prerst_ready", 32'(in_ready_o), 32'd0);
    #2 rst_i = 1'b1;
    #1;
    exp_q.delete();
    check("arst_valid", 32'(sym_valid_o), 32'd0);
    check("arst_level", 32'(level_o), 32'd0);
    check("arst_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    sym_ready_i = 1'b1;
    send_word(32'h0000C3A5, 4'b0011, 2'b01);
    wait_empty("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
